// File: rtl/computation_operand_loader_if.sv
//------------------------------------------------------------------------------
// Module      : computation_operand_loader_if
// Description : Operand byte-stream and result valid/ready bundle for the
//               dot-product operand loader.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface computation_operand_loader_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );
endinterface

`default_nettype wire

// File: rtl/computation_operand_loader.sv
//------------------------------------------------------------------------------
// Module      : computation_operand_loader
// Description : Assembles x0..x7 / w0..w7 from a byte stream, waits for the
//               dot-product tree to settle and hands the result downstream.
//               Optional macro COMPUTATION_WEIGHT_KEEP_EN adds w_keep
//               (8-byte frames that reuse the previous weights).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module computation_operand_loader #(
   parameter int SETTLE_CYCLES = 2      // legal range 1..15
) (
   input  wire logic                    clk,
   input  wire logic                    rst_n,
   computation_operand_loader_if.slave  io,
`ifdef COMPUTATION_WEIGHT_KEEP_EN
   input  wire logic                    w_keep,
`endif
   input  wire logic [7:0]              result_in,
   output logic      [7:0]              x0,
   output logic      [7:0]              x1,
   output logic      [7:0]              x2,
   output logic      [7:0]              x3,
   output logic      [7:0]              x4,
   output logic      [7:0]              x5,
   output logic      [7:0]              x6,
   output logic      [7:0]              x7,
   output logic      [7:0]              w0,
   output logic      [7:0]              w1,
   output logic      [7:0]              w2,
   output logic      [7:0]              w3,
   output logic      [7:0]              w4,
   output logic      [7:0]              w5,
   output logic      [7:0]              w6,
   output logic      [7:0]              w7,
   output logic                         busy
);

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // Counter runs 0..SETTLE_CYCLES so capture lands SETTLE_CYCLES+1 edges after w7.
   localparam logic [3:0] c_settle_done = 4'(SETTLE_CYCLES);

   state_t     state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] x_q [8];
   logic [7:0] x_d [8];
   logic [7:0] w_q [8];
   logic [7:0] w_d [8];
   logic [7:0] out_data_q, out_data_d;
   logic       out_valid_q, out_valid_d;
   logic       frame_end;
`ifdef COMPUTATION_WEIGHT_KEEP_EN
   logic       keep_q, keep_d;
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      x_d         = x_q;
      w_d         = w_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      frame_end   = (idx_q == 4'd15);
`ifdef COMPUTATION_WEIGHT_KEEP_EN
      keep_d      = keep_q;
      // keep_q was latched with x0, so it is current by the time x7 arrives
      if (keep_q && (idx_q == 4'd7)) begin
         frame_end = 1'b1;
      end
`endif

      case (state_q)
         ST_LOAD: begin
            if (io.in_valid) begin
               if (!idx_q[3]) begin
                  x_d[idx_q[2:0]] = io.in_data;
               end else begin
                  w_d[idx_q[2:0]] = io.in_data;
               end
               idx_d = idx_q + 4'd1;
`ifdef COMPUTATION_WEIGHT_KEEP_EN
               if (idx_q == 4'd0) begin
                  keep_d = w_keep;
               end
`endif
               if (frame_end) begin
                  state_d = ST_SETTLE;
                  idx_d   = 4'd0;
                  cnt_d   = 4'd0;
               end
            end
         end

         ST_SETTLE: begin
            if (cnt_q == c_settle_done) begin
               out_data_d  = result_in;
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
               cnt_d       = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end

         ST_DONE: begin
            if (io.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_LOAD;
            end
         end

         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_LOAD;
         idx_q       <= 4'd0;
         cnt_q       <= 4'd0;
         x_q         <= '{default: 8'd0};
         w_q         <= '{default: 8'd0};
         out_data_q  <= 8'd0;
         out_valid_q <= 1'b0;
`ifdef COMPUTATION_WEIGHT_KEEP_EN
         keep_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         w_q         <= w_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
`ifdef COMPUTATION_WEIGHT_KEEP_EN
         keep_q      <= keep_d;
`endif
      end
   end

   assign io.in_ready  = (state_q == ST_LOAD);
   assign io.out_valid = out_valid_q;
   assign io.out_data  = out_data_q;
   assign busy         = (state_q != ST_LOAD);

   assign x0 = x_q[0];
   assign x1 = x_q[1];
   assign x2 = x_q[2];
   assign x3 = x_q[3];
   assign x4 = x_q[4];
   assign x5 = x_q[5];
   assign x6 = x_q[6];
   assign x7 = x_q[7];
   assign w0 = w_q[0];
   assign w1 = w_q[1];
   assign w2 = w_q[2];
   assign w3 = w_q[3];
   assign w4 = w_q[4];
   assign w5 = w_q[5];
   assign w6 = w_q[6];
   assign w7 = w_q[7];

endmodule

`default_nettype wire
